// File: rtl/fp_pkg.sv
// Shared constants for the floating-point add/subtract unit: rounding modes,
// flag bit positions and the binary32 default geometry.
package fp_pkg;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RDN = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RTZ = 2'b11;

    // flags bus is {NV,OF,UF,NX}
    localparam int FLG_NX = 0;
    localparam int FLG_UF = 1;
    localparam int FLG_OF = 2;
    localparam int FLG_NV = 3;

    localparam int FP_EXP_W  = 8;
    localparam int FP_FRAC_W = 23;
    localparam int FP_BIAS   = 2 ** (FP_EXP_W - 1) - 1;
    localparam int FP_MAN_W  = FP_FRAC_W + 1;
    localparam int FP_GRS_W  = FP_FRAC_W + 4;

endpackage

// File: rtl/fp_addsub_norm.sv
// Combinational back end of the adder: normalise the raw sum, round it, and
// substitute overflow, zero, infinity and NaN results with their flags.
module fp_addsub_norm
    import fp_pkg::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int FRAC_W = FP_FRAC_W
) (
    input  logic [1:0]            rm,
    input  logic                  sign,
    input  logic                  op_sub,
    input  logic [EXP_W-1:0]      exp,
    input  logic [FRAC_W+4:0]     sum,
    input  logic                  spc_nan,
    input  logic                  spc_nv,
    input  logic                  spc_inf,
    input  logic                  spc_sign,
    input  logic [FRAC_W-1:0]     nan_frac,
    output logic [EXP_W+FRAC_W:0] res,
    output logic [3:0]            flags
);
    localparam int MAN_W = FRAC_W + 1;
    localparam int GRS_W = FRAC_W + 4;
    localparam int EE_W  = EXP_W + 2;
    localparam int LZ_W  = $clog2(GRS_W + 1);

    function automatic logic [LZ_W-1:0] lzc(input logic [GRS_W-1:0] v);
        lzc = LZ_W'(GRS_W);
        for (int i = 0; i < GRS_W; i++)
            if (v[i]) lzc = LZ_W'(GRS_W - 1 - i);
    endfunction

    logic [GRS_W-1:0]  ext;
    logic [EE_W-1:0]   e;
    logic [EE_W-1:0]   sh;
    logic [LZ_W-1:0]   lz;
    logic [MAN_W:0]    mant_r;
    logic [FRAC_W-1:0] frac;
    logic              inexact, inc, tiny, ovf, to_inf;

    always_comb begin
        ext = sum[GRS_W-1:0];
        e   = {2'b00, exp};
        lz  = '0;
        sh  = '0;
        if (sum[GRS_W]) begin
            ext = {sum[GRS_W:2], sum[1] | sum[0]};
            e   = e + EE_W'(1);
        end else begin
            // Left shift never takes the exponent below 1; landing on 1
            // without a hidden bit means the result is subnormal.
            lz  = lzc(sum[GRS_W-1:0]);
            sh  = (EE_W'(lz) < e - EE_W'(1)) ? EE_W'(lz) : e - EE_W'(1);
            ext = sum[GRS_W-1:0] << sh;
            e   = e - sh;
            if (!ext[GRS_W-1]) e = '0;
        end
        tiny    = (e == '0);
        inexact = ext[2] | ext[1] | ext[0];
        case (rm)
            RM_RNE:  inc = ext[2] & (ext[1] | ext[0] | ext[3]);
            RM_RDN:  inc = sign & inexact;
            RM_RUP:  inc = ~sign & inexact;
            default: inc = 1'b0;
        endcase
        mant_r = {1'b0, ext[GRS_W-1:3]} + (MAN_W + 1)'(inc);
        if (mant_r[MAN_W]) begin
            e    = e + EE_W'(1);
            frac = mant_r[FRAC_W:1];
        end else begin
            frac = mant_r[FRAC_W-1:0];
            if (e == '0 && mant_r[FRAC_W]) e = EE_W'(1);
        end
        ovf    = (e >= EE_W'((1 << EXP_W) - 1));
        to_inf = (rm == RM_RNE) | ((rm == RM_RDN) & sign) | ((rm == RM_RUP) & ~sign);

        res           = {sign, e[EXP_W-1:0], frac};
        flags         = '0;
        flags[FLG_NX] = inexact;
        flags[FLG_UF] = tiny & inexact;
        if (ovf) begin
            res           = to_inf ? {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}}
                                   : {sign, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
            flags[FLG_OF] = 1'b1;
            flags[FLG_NX] = 1'b1;
        end
        if (sum == '0)
            res = {(op_sub ? (rm == RM_RDN) : sign), {(EXP_W+FRAC_W){1'b0}}};
        if (spc_inf) begin
            res   = {spc_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            flags = '0;
        end
        if (spc_nan) begin
            res           = {spc_sign, {EXP_W{1'b1}}, nan_frac};
            flags         = '0;
            flags[FLG_NV] = spc_nv;
        end
    end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage IEEE-754 add/subtract (align, calculate, normalise/round) with a
// valid/ready handshake per stage, sideband tag and exception flags.
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int FRAC_W = FP_FRAC_W,
    parameter int TAG_W  = 4
) (
    input  logic                  clock,
    input  logic                  clrn,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [EXP_W+FRAC_W:0] a,
    input  logic [EXP_W+FRAC_W:0] b,
    input  logic                  sub,
    input  logic [1:0]            rm,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_W+FRAC_W:0] s,
    output logic [TAG_W-1:0]      out_tag,
    output logic [3:0]            flags
);
    localparam int W     = 1 + EXP_W + FRAC_W;
    localparam int MAN_W = FRAC_W + 1;
    localparam int GRS_W = FRAC_W + 4;
    localparam int SUM_W = FRAC_W + 5;
    localparam int SH_W  = $clog2(GRS_W);

    typedef struct packed {
        logic              sign;
        logic              op_sub;
        logic [EXP_W-1:0]  exp;
        logic [MAN_W-1:0]  man_l;
        logic [GRS_W-1:0]  man_s;
        logic [1:0]        rm;
        logic [TAG_W-1:0]  tag;
        logic              nan, nv, inf, spc_sign;
        logic [FRAC_W-1:0] nan_frac;
    } r1_t;

    typedef struct packed {
        logic              sign;
        logic              op_sub;
        logic [EXP_W-1:0]  exp;
        logic [SUM_W-1:0]  sum;
        logic [1:0]        rm;
        logic [TAG_W-1:0]  tag;
        logic              nan, nv, inf, spc_sign;
        logic [FRAC_W-1:0] nan_frac;
    } r2_t;

    r1_t r1_d, r1_q;
    r2_t r2_d, r2_q;
    logic ready_en_q, v1_q, v2_q, v3_q, v1_d, v2_d, v3_d, r2_rdy, r3_rdy, ld3;
    logic [W-1:0] s_d, s_q, res_n;
    logic [TAG_W-1:0] out_tag_d, out_tag_q;
    logic [3:0] flags_d, flags_q, flags_n;

    logic sa, sbe, a_ge, sl, a_nan, b_nan, a_inf, b_inf, two_inf, lost;
    logic [EXP_W-1:0] ea, eb, el, es, el_eff, es_eff, diff;
    logic [FRAC_W-1:0] fa, fb, fl, fs;
    logic [SH_W-1:0] shamt;
    logic [GRS_W-1:0] ms_ext, ms_sh;

    assign sa  = a[W-1];
    assign sbe = b[W-1] ^ sub;
    assign ea  = a[W-2:FRAC_W];
    assign eb  = b[W-2:FRAC_W];
    assign fa  = a[FRAC_W-1:0];
    assign fb  = b[FRAC_W-1:0];

    // Stage 1: order by magnitude and align the smaller mantissa with G/R/sticky.
    always_comb begin
        a_ge   = a[W-2:0] >= b[W-2:0];
        sl     = a_ge ? sa : sbe;
        el     = a_ge ? ea : eb;
        es     = a_ge ? eb : ea;
        fl     = a_ge ? fa : fb;
        fs     = a_ge ? fb : fa;
        el_eff = (el == '0) ? EXP_W'(1) : el;
        es_eff = (es == '0) ? EXP_W'(1) : es;
        diff   = el_eff - es_eff;
        shamt  = (int'(diff) >= GRS_W - 1) ? SH_W'(GRS_W - 1) : SH_W'(diff);
        ms_ext = {es != '0, fs, 3'b000};
        ms_sh  = ms_ext >> shamt;
        lost   = |(ms_ext & ~({GRS_W{1'b1}} << shamt));
        a_nan  = (&ea) & (|fa);
        b_nan  = (&eb) & (|fb);
        a_inf  = (&ea) & ~(|fa);
        b_inf  = (&eb) & ~(|fb);
        two_inf = a_inf & b_inf & (sa ^ sbe);

        r1_d.sign     = sl;
        r1_d.op_sub   = sa ^ sbe;
        r1_d.exp      = el_eff;
        r1_d.man_l    = {el != '0, fl};
        r1_d.man_s    = {ms_sh[GRS_W-1:1], ms_sh[0] | lost};
        r1_d.rm       = rm;
        r1_d.tag      = in_tag;
        r1_d.nan      = a_nan | b_nan | two_inf;
        r1_d.nv       = (a_nan & ~fa[FRAC_W-1]) | (b_nan & ~fb[FRAC_W-1]) | two_inf;
        r1_d.inf      = (a_inf | b_inf) & ~r1_d.nan;
        r1_d.spc_sign = r1_d.nan ? sl : (a_inf ? sa : sbe);
        r1_d.nan_frac = ((fa >= fb) ? fa : fb) | {1'b1, {(FRAC_W-1){1'b0}}};
    end

    // Stage 2: magnitude add or subtract; large >= small so no borrow out.
    always_comb begin
        r2_d.sign     = r1_q.sign;
        r2_d.op_sub   = r1_q.op_sub;
        r2_d.exp      = r1_q.exp;
        r2_d.sum      = r1_q.op_sub ? ({1'b0, r1_q.man_l, 3'b000} - {1'b0, r1_q.man_s})
                                    : ({1'b0, r1_q.man_l, 3'b000} + {1'b0, r1_q.man_s});
        r2_d.rm       = r1_q.rm;
        r2_d.tag      = r1_q.tag;
        r2_d.nan      = r1_q.nan;
        r2_d.nv       = r1_q.nv;
        r2_d.inf      = r1_q.inf;
        r2_d.spc_sign = r1_q.spc_sign;
        r2_d.nan_frac = r1_q.nan_frac;
    end

    // Stage 3: normalise, round and select special results.
    fp_addsub_norm #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_norm (
        .rm       (r2_q.rm),
        .sign     (r2_q.sign),
        .op_sub   (r2_q.op_sub),
        .exp      (r2_q.exp),
        .sum      (r2_q.sum),
        .spc_nan  (r2_q.nan),
        .spc_nv   (r2_q.nv),
        .spc_inf  (r2_q.inf),
        .spc_sign (r2_q.spc_sign),
        .nan_frac (r2_q.nan_frac),
        .res      (res_n),
        .flags    (flags_n)
    );

    always_comb begin
        r3_rdy    = ~v3_q | out_ready;
        r2_rdy    = ~v2_q | r3_rdy;
        in_ready  = ready_en_q & (~v1_q | r2_rdy);
        v1_d      = flush ? 1'b0 : (in_ready ? in_valid : v1_q);
        v2_d      = flush ? 1'b0 : (r2_rdy ? v1_q : v2_q);
        v3_d      = flush ? 1'b0 : (r3_rdy ? v2_q : v3_q);
        ld3       = r3_rdy & v2_q;
        s_d       = ld3 ? res_n : s_q;
        out_tag_d = ld3 ? r2_q.tag : out_tag_q;
        flags_d   = ld3 ? flags_n : flags_q;
    end

    always_ff @(posedge clock) begin
        if (in_ready && in_valid) r1_q <= r1_d;
        if (r2_rdy && v1_q)       r2_q <= r2_d;
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            ready_en_q <= 1'b0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            v3_q       <= 1'b0;
            s_q        <= '0;
            out_tag_q  <= '0;
            flags_q    <= '0;
        end else begin
            ready_en_q <= 1'b1;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            v3_q       <= v3_d;
            s_q        <= s_d;
            out_tag_q  <= out_tag_d;
            flags_q    <= flags_d;
        end
    end

    assign out_valid = v3_q;
    assign s         = s_q;
    assign out_tag   = out_tag_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe in its binary32 configuration.
module tb_fp_addsub_pipe;
    import fp_pkg::*;

    logic        clock = 1'b0;
    logic        clrn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        sub = 1'b0;
    logic [1:0]  rm = 2'b00;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] s;
    logic [3:0]  out_tag;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;
    int n_acc, n_got, stale;

    logic [31:0] st_a [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                              32'h40800000, 32'h40A00000, 32'h40C00000};
    logic [31:0] st_s [6] = '{32'h40000000, 32'h40400000, 32'h40800000,
                              32'h40A00000, 32'h40C00000, 32'h40E00000};
    logic [3:0]  st_t [6] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

    always #5 clock = ~clock;

    fp_addsub_pipe #(.EXP_W(8), .FRAC_W(23), .TAG_W(4)) dut (
        .clock(clock), .clrn(clrn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .rm(rm), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .s(s), .out_tag(out_tag), .flags(flags)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, req);
        end
    endtask

    task automatic drive(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                         input logic [1:0] irm, input logic [3:0] itag);
        a = ia; b = ib; sub = isub; rm = irm; in_tag = itag; in_valid = 1'b1;
    endtask

    task automatic run_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                          input logic isub, input logic [1:0] irm,
                          input logic [31:0] es, input logic [3:0] ef);
        int n = 0;
        @(negedge clock);
        drive(ia, ib, isub, irm, 4'h3);
        @(negedge clock);
        in_valid = 1'b0;
        while (!out_valid && n < 10) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_s"}, s, es);
        chk({tag, "_flags"}, 32'(flags), 32'(ef));
    endtask

    initial begin
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_s", s, 32'd0);
        chk("rst_tag", 32'(out_tag), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        @(negedge clock);
        @(negedge clock);
        clrn = 1'b1;
        @(negedge clock);
        chk("rdy_after_rst", 32'(in_ready), 32'd1);

        // 1.0 + 1.0 with latency and tag echo
        drive(32'h3F800000, 32'h3F800000, 1'b0, RM_RNE, 4'h9);
        @(negedge clock);
        in_valid = 1'b0;
        chk("lat_c1", 32'(out_valid), 32'd0);
        @(negedge clock);
        chk("lat_c2", 32'(out_valid), 32'd0);
        @(negedge clock);
        chk("lat_c3", 32'(out_valid), 32'd1);
        chk("one_s", s, 32'h40000000);
        chk("one_flags", 32'(flags), 32'd0);
        chk("one_tag", 32'(out_tag), 32'h9);

        run_op("ovf_rne", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, RM_RNE, 32'h7F800000, 4'h5);
        run_op("ovf_rtz", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, RM_RTZ, 32'h7F7FFFFF, 4'h5);
        run_op("ovf_rdn", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, RM_RDN, 32'h7F7FFFFF, 4'h5);
        run_op("ovf_rup_neg", 32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, RM_RUP, 32'hFF7FFFFF, 4'h5);
        run_op("inf_m_inf", 32'h7F800000, 32'h7F800000, 1'b1, RM_RNE, 32'h7FC00000, 4'h8);
        run_op("denorm_add", 32'h00000001, 32'h00000001, 1'b0, RM_RNE, 32'h00000002, 4'h0);
        run_op("denorm_sub", 32'h00800000, 32'h00000001, 1'b1, RM_RNE, 32'h007FFFFF, 4'h0);
        run_op("zero_rne", 32'h3F800000, 32'h3F800000, 1'b1, RM_RNE, 32'h00000000, 4'h0);
        run_op("zero_rdn", 32'h3F800000, 32'h3F800000, 1'b1, RM_RDN, 32'h80000000, 4'h0);
        run_op("tie_rne", 32'h3F800000, 32'h33800000, 1'b0, RM_RNE, 32'h3F800000, 4'h1);
        run_op("tie_rup", 32'h3F800000, 32'h33800000, 1'b0, RM_RUP, 32'h3F800001, 4'h1);
        run_op("snan", 32'h7F800001, 32'h3F800000, 1'b0, RM_RNE, 32'h7FC00001, 4'h8);
        run_op("qnan", 32'h7FC00000, 32'h3F800000, 1'b0, RM_RNE, 32'h7FC00000, 4'h0);
        run_op("inf_fin", 32'hFF800000, 32'h3F800000, 1'b0, RM_RNE, 32'hFF800000, 4'h0);

        // back-pressure: capacity 3, then ordered drain
        @(negedge clock);
        out_ready = 1'b0;
        n_acc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            drive(st_a[n_acc], 32'h3F800000, 1'b0, RM_RNE, st_t[n_acc]);
            if (in_ready) n_acc++;
        end
        chk("bp_accepted", 32'(n_acc), 32'd3);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        n_got = 0;
        for (int c = 0; c < 40 && n_got < 6; c++) begin
            if (out_valid) begin
                chk($sformatf("bp_s%0d", n_got), s, st_s[n_got]);
                chk($sformatf("bp_tag%0d", n_got), 32'(out_tag), 32'(st_t[n_got]));
                n_got++;
            end
            if (n_acc < 6) begin
                drive(st_a[n_acc], 32'h3F800000, 1'b0, RM_RNE, st_t[n_acc]);
                if (in_ready) n_acc++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clock);
        end
        in_valid = 1'b0;
        chk("bp_count", 32'(n_got), 32'd6);
        @(negedge clock);
        chk("bp_no_dup", 32'(out_valid), 32'd0);

        // async reset with three ops in flight
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            drive(st_a[c], 32'h3F800000, 1'b0, RM_RNE, st_t[c]);
        end
        @(negedge clock);
        in_valid = 1'b0;
        chk("rst_full", 32'(out_valid), 32'd1);
        #2 clrn = 1'b0;
        #1;
        chk("rst_async_valid", 32'(out_valid), 32'd0);
        chk("rst_async_s", s, 32'd0);
        @(negedge clock);
        clrn = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clock);
            if (out_valid) stale++;
        end
        chk("rst_no_stale", 32'(stale), 32'd0);
        run_op("post_rst", 32'h40000000, 32'h3F800000, 1'b0, RM_RNE, 32'h40400000, 4'h0);

        // synchronous flush with three in flight and a beat offered
        @(negedge clock);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            drive(st_a[c], 32'h3F800000, 1'b0, RM_RNE, st_t[c]);
        end
        @(negedge clock);
        chk("flush_full", 32'(out_valid), 32'd1);
        drive(st_a[3], 32'h3F800000, 1'b0, RM_RNE, st_t[3]);
        out_ready = 1'b1;
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        stale = 0;
        repeat (6) begin
            @(negedge clock);
            if (out_valid) stale++;
        end
        chk("flush_no_stale", 32'(stale), 32'd0);
        run_op("post_flush", 32'h40800000, 32'h3F800000, 1'b0, RM_RNE, 32'h40A00000, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
